// File: rtl/uop_fetch_seq_pkg.sv
// Shared definitions for the uop cache read-side sequencer.
package uop_fetch_seq_pkg;

  // Geometry shared with the uop cache.
  localparam int UOP_W      = 32;
  localparam int UOP_ADDR_W = 6;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/uop_fetch_seq_fifo.sv
// First-word-fall-through FIFO holding micro-ops plus their last tag.
module uop_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CNT_FULL) || do_pop);

  // Pointer and occupancy update; clear wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/uop_fetch_seq.sv
// Drains a run of consecutive micro-ops from the uop cache into a valid/ready stream.
module uop_fetch_seq
  import uop_fetch_seq_pkg::*;
#(
  parameter int ADDR_W     = UOP_ADDR_W,
  parameter int DATA_W     = UOP_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              flush,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int             CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              vld_p1_q, vld_p1_d;   // cache read issued last cycle
  logic              last_p1_q, last_p1_d; // that read is the final one of the run
  logic              done_q, done_d;

  logic              issue;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W:0]   fifo_head;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    credit_used;

  // Buffered entries plus the one possibly in flight must fit in the FIFO.
  assign credit_used = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, vld_p1_q};
  assign issue = (state_q == ST_FETCH) && (rem_q != '0) &&
                 (credit_used < CREDIT_MAX) && !flush;
  assign pop   = !fifo_empty && out_ready;

  // Next-state, counter and in-flight tag logic; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    vld_p1_d  = issue;
    last_p1_d = issue && (rem_q == (ADDR_W + 1)'(1));
    done_d    = 1'b0;
    if (flush) begin
      state_d   = ST_IDLE;
      vld_p1_d  = 1'b0;
      last_p1_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr_d  = start_addr;
              rem_d   = length;
              state_d = ST_FETCH;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (issue) begin
            addr_d = addr_q + ADDR_W'(1);
            rem_d  = rem_q - (ADDR_W + 1)'(1);
            if (rem_q == (ADDR_W + 1)'(1)) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && fifo_head[DATA_W]) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      done_q    <= done_d;
    end
  end

  // Read results land here the cycle after issue; flush clears it and drops the in-flight word.
  uop_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (flush),
    .push      (vld_p1_q),
    .push_data ({last_p1_q, rd_data}),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign rd_en     = issue;
  assign rd_addr   = addr_q;
  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign out_last  = !fifo_empty && fifo_head[DATA_W];
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_uop_fetch_seq.sv
// Randomized bench for uop_fetch_seq with a cache model and a queue-based reference.
module tb_uop_fetch_seq;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int N          = 64;
  localparam int MAX_CYC    = 2000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W:0]   length;
  logic              flush;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DATA_W-1:0] cache [N];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uop_fetch_seq #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .flush      (flush),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Cache model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) rd_data <= rd_en ? cache[rd_addr] : $urandom();

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One run: expected stream is cache[(sa+i)%64], last on the final element.
  task automatic run(input int sa, input int len, input int rdy_pct,
                     input int stall_cycles, input int flush_after);
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_last_q[$];
    logic [DATA_W-1:0] held;
    logic              held_vld = 1'b0;
    bit flushed = 0;
    int reads = 0, pops = 0, cyc, fcyc = 0;
    int last_hs = (len == 0) ? 0 : -1;
    int first_vld = -1, first_rd = -1, last_rd = -1;
    int done_cnt = 0, done_cyc = 0, stall_reads = 0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(cache[(sa + i) % N]);
      exp_last_q.push_back(i == len - 1);
    end
    @(negedge clk);
    start      = 1'b1;
    start_addr = sa[ADDR_W-1:0];
    length     = len[ADDR_W:0];
    out_ready  = 1'b0;
    #1 chk("start_no_rd", rd_en, 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < MAX_CYC) begin
      out_ready = (cyc <= stall_cycles) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      flush = (flush_after >= 0) && (pops == flush_after) && !flushed && busy;
      if (flush) out_ready = 1'b0;
      #1;
      if (flush) begin
        flushed = 1;
        fcyc = cyc;
      end else if (flushed) begin
        chk("flush_vld", out_valid, 0);
        chk("flush_rd", rd_en, 0);
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        if (cyc >= fcyc + 5) break;
      end else begin
        if (rd_en) begin
          chk("rd_addr", rd_addr, (sa + reads) % N);
          reads++;
          chk("credit", (reads - pops) <= FIFO_DEPTH, 1);
          if (cyc <= stall_cycles) stall_reads++;
          if (first_rd < 0) first_rd = cyc;
          last_rd = cyc;
        end
        if (held_vld) begin
          chk("no_retract", out_valid, 1);
          chk("hold", out_instr, held);
        end
        if (out_valid && first_vld < 0) first_vld = cyc;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("extra_out", 1, 0);
          else begin
            chk("instr", out_instr, exp_q.pop_front());
            chk("last", out_last, exp_last_q.pop_front());
          end
          pops++;
          if (out_last) last_hs = cyc;
        end
        held_vld = out_valid && !out_ready;
        held     = out_instr;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          chk("done_timing", cyc, last_hs + 1);
          chk("busy_at_done", busy, 0);
        end
        if (done_cnt > 0 && cyc >= done_cyc + 3) break;
      end
      cyc++;
      @(negedge clk);
    end
    flush = 1'b0;
    chk("timeout", cyc < MAX_CYC, 1);
    if (!flushed) begin
      chk("done_cnt", done_cnt, 1);
      chk("all_out", exp_q.size(), 0);
      chk("reads", reads, len);
      if (stall_cycles > 0)
        chk("stall_reads", stall_reads, (len < FIFO_DEPTH) ? len : FIFO_DEPTH);
      if (len > 0 && rdy_pct >= 100 && stall_cycles == 0) begin
        chk("latency", first_vld, 3);
        chk("throughput", last_rd - first_rd, len - 1);
      end
    end
  endtask

  // Asynchronous reset in the middle of FETCH with two words buffered.
  task automatic reset_mid();
    @(negedge clk);
    start = 1'b1; start_addr = 6'd10; length = 7'd10; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("pre_rst_vld", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 chk("post_rst_vld", out_valid, 0);
      chk("post_rst_rd", rd_en, 0);
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; flush = 1'b0; out_ready = 1'b0;
    start_addr = '0; length = '0;
    for (int i = 0; i < N; i++) cache[i] = 32'hA000_0000 + i;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_vld", out_valid, 0);
    chk("reset_instr", out_instr, 0);
    chk("reset_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b1;

    run(5, 3, 100, 0, -1);
    run(62, 4, 100, 0, -1);
    run(0, 10, 100, 20, -1);
    run(0, 64, 100, 0, -1);
    run(0, 0, 100, 0, -1);
    run(0, 8, 100, 0, 3);
    run(20, 1, 100, 0, -1);
    reset_mid();
    run(20, 1, 100, 0, -1);

    for (int i = 0; i < N; i++) cache[i] = $urandom();
    for (int r = 0; r < 30; r++) begin
      int sa  = $urandom_range(N - 1);
      int len = $urandom_range(N);
      int pct = $urandom_range(100, 20);
      int stl = ($urandom_range(3) == 0) ? $urandom_range(12, 1) : 0;
      int fa  = ($urandom_range(3) == 0) ? $urandom_range(len) : -1;
      run(sa, len, pct, stl, fa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uop_fetch_seq.md
Name: uop_fetch_seq

Overview:
- Read-side sequencer that drains a run of consecutive micro-ops out of the 64-entry uop cache (1-cycle synchronous read latency, 32-bit entries) toward the decode stage.
- Sits directly downstream of the uop cache. It drives the cache read_enable/read_address, captures the cache output one cycle later into a small FIFO, and presents the micro-ops on a valid/ready stream with a last marker.

Parameters:
- ADDR_W, 6, cache address width (64 entries)
- DATA_W, 32, micro-op width
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse: begin a run; sampled only in IDLE
- start_addr  in  ADDR_W  first cache entry of the run
- length  in  ADDR_W+1  number of micro-ops, 0..64
- flush  in  1  abort the current run, discard all buffered/in-flight data
- rd_en  out  1  cache read enable
- rd_addr  out  ADDR_W  cache read address
- rd_data  in  DATA_W  cache output, valid the cycle after rd_en
- out_valid  out  1  micro-op available
- out_ready  in  1  decode accepts micro-op
- out_instr  out  DATA_W  micro-op
- out_last  out  1  qualifies the final micro-op of the run
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at run completion

Behaviour:
- Reset (reset=0, async): state IDLE; rd_en=0, rd_addr=0, out_valid=0, out_instr=0, out_last=0, busy=0, done=0; FIFO empty; in-flight flag clear.
- States: IDLE, FETCH, DRAIN.
- IDLE, start=1, length>0: latch start_addr into the address counter and length into the remaining counter; busy=1; go to FETCH. No read is issued in the start cycle.
- IDLE, start=1, length=0: no reads; done=1 the next cycle; busy stays 0.
- start outside IDLE is ignored.
- FETCH: issue rd_en=1 when remaining>0 and (FIFO occupancy + in-flight) < FIFO_DEPTH. This credit rule guarantees the FIFO never overflows.
- Each issue: rd_addr = current address; address increments modulo 64 (63 wraps to 0); remaining decrements.
- The issue that takes remaining to 0 also sets a last tag on that in-flight read. Go to DRAIN.
- The cycle after any rd_en: push rd_data into the FIFO with its last tag. rd_data is ignored in all other cycles.
- Output: out_valid = FIFO non-empty; out_instr/out_last come from the FIFO head (first-word-fall-through). Pop on out_valid & out_ready.
- Push and pop in the same cycle are both honoured.
- Full throughput: with out_ready held high, one micro-op per cycle after an initial 2-cycle latency (start -> first out_valid = 2 cycles after the FETCH entry cycle).
- DRAIN: wait for the out_last handshake. On that cycle return to IDLE and drop busy. done=1 on the following cycle.
- flush (any state, priority over everything else):
  - next cycle: IDLE, FIFO emptied, in-flight read result discarded, rd_en=0, busy=0;
  - no done pulse;
  - a start coincident with flush is ignored.
- out_instr holds its value while out_valid=1 and out_ready=0. The stream is never retracted except by flush or reset.
- The sequencer never writes the cache. A cache write to the address being read in the same cycle is the cache's collision behaviour and is not handled here.

Decomposition:
- Shared package:
  - state encoding constants (IDLE/FETCH/DRAIN);
  - UOP_W=32 and UOP_ADDR_W=6, common with the uop cache.
- One sub-module: uop_fifo. Synchronous FIFO of DATA_W+1 bits (micro-op plus last tag), FIFO_DEPTH entries, first-word-fall-through, with an occupancy count output.
- The FSM, counters and credit logic live in the top module.

Test Plan:
- Reset mid-run: assert reset during FETCH with 2 items buffered -> all outputs 0 immediately; FIFO empty after release.
- Basic run: cache preloaded entry[i]=0xA000_0000+i; start_addr=5, length=3, out_ready=1 -> rd_addr 5,6,7 on consecutive cycles; out_instr A0000005, A0000006, A0000007 with out_last on the third; done pulses once, 1 cycle after the last handshake.
- Wrap: start_addr=62, length=4 -> rd_addr 62,63,0,1; outputs in that order.
- Backpressure: length=10, out_ready=0 for 20 cycles, then 1 -> exactly FIFO_DEPTH reads issued while stalled; afterwards all 10 delivered in order with no loss or duplication; out_instr stable while stalled.
- Full length and zero length: length=64 from addr 0 -> 64 micro-ops, last = entry 63. length=0 -> no rd_en, done the next cycle.
- Flush: flush during FETCH of length=8 after 3 outputs -> out_valid=0 the next cycle, no done. A following run start_addr=20, length=1 returns entry 20 with out_last.
